// File: rtl/conv_pkg.sv
// Shared definitions for the conv2 result streaming path: stream FSM states,
// result-edge helper and default pixel width.
package conv_pkg;

  localparam int DEFAULT_WIDTH_BIT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_e;

  // Edge length of a valid (no padding) convolution result.
  function automatic int out_size(input int size, input int size_ker);
    return size - size_ker + 1;
  endfunction

endpackage

// File: rtl/conv_result_streamer_raster_counter.sv
// raster_counter: row/col walk over an OUT x OUT matrix in raster order.
// The counters point at the element to be loaded next; o_eol/o_eof describe
// that element so the flags can be registered alongside its data.
module raster_counter
  import conv_pkg::*;
#(
  parameter int OUT = 3,
  parameter int CW  = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_eol,
  output logic          o_eof
);

  localparam logic [CW-1:0] LAST = CW'(OUT - 1);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  assign o_row = r_row;
  assign o_col = r_col;
  assign o_eol = (r_col == LAST);
  assign o_eof = (r_row == LAST) && (r_col == LAST);

  // Step col each advance, wrapping into the next row; the last element wraps to the origin.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: streams the conv2 result matrix one signed pixel per
// beat in raster order on a valid/ready interface with eol/eof markers.
// Optional build macro CONV_STREAM_RELU_EN clamps negative pixels to zero on
// the registered output path (no added latency).
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int SIZE      = 320,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = DEFAULT_WIDTH_BIT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] convIxKernelOut [0:SIZE-SIZEKer][0:SIZE-SIZEKer],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic                        out_eol,
  output logic                        out_eof,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int OUT = out_size(SIZE, SIZEKer);
  localparam int CW  = (OUT > 1) ? $clog2(OUT) : 1;

  stream_state_e r_state;
  stream_state_e w_next;

  logic                        r_valid;
  logic signed [WIDTH_BIT-1:0] r_data;
  logic                        r_eol;
  logic                        r_eof;

  logic [CW-1:0]               w_row;
  logic [CW-1:0]               w_col;
  logic                        w_eol;
  logic                        w_eof;
  logic                        w_start_ok;
  logic                        w_load;
  logic                        w_last_fire;
  logic signed [WIDTH_BIT-1:0] w_pixel_raw;
  logic signed [WIDTH_BIT-1:0] w_pixel;

  // Start only counts in IDLE; while streaming, reload whenever the register is
  // free or being drained, until the eof beat is already sitting in it.
  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_last_fire = r_valid && out_ready && r_eof;
  assign w_load      = w_start_ok
                    || ((r_state == STREAM) && (!r_valid || out_ready) && !r_eof);

  raster_counter #(
    .OUT (OUT),
    .CW  (CW)
  ) u_raster (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_last_fire),
    .i_advance (w_load),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_eol     (w_eol),
    .o_eof     (w_eof)
  );

  assign w_pixel_raw = convIxKernelOut[w_row][w_col];

`ifdef CONV_STREAM_RELU_EN
  assign w_pixel = w_pixel_raw[WIDTH_BIT-1] ? '0 : w_pixel_raw;
`else
  assign w_pixel = w_pixel_raw;
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus the state-derived status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_next     = r_state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = STREAM;
      STREAM: begin
        busy = 1'b1;
        if (w_last_fire) w_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output register: load the next pixel on a free slot, drop valid after the
  // eof handshake, otherwise hold everything stable while valid is pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_pixel;
      r_eol   <= w_eol;
      r_eof   <= w_eof;
    end else if (w_last_fire) begin
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_eol   = r_eol;
  assign out_eof   = r_eof;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer with SIZE=5, SIZEKer=3 (3x3
// result, 9 beats per frame). Expected beats are queued when a frame starts
// and a negedge monitor pops and compares every accepted beat.
module tb_conv_result_streamer;

  localparam int OUT = 3;
  localparam int NB  = OUT * OUT;

  typedef struct {
    logic signed [15:0] data;
    logic               eol;
    logic               eof;
  } beat_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic signed [15:0] mat [0:OUT-1][0:OUT-1];
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_eol;
  logic               out_eof;
  logic               busy;
  logic               frame_done;

  logic  ready_level = 1'b1;
  logic  rnd_ready   = 1'b1;
  logic  rand_mode   = 1'b0;

  beat_t exp_q[$];
  int    n_checks   = 0;
  int    n_pass     = 0;
  int    n_accepted = 0;
  int    fd_cnt     = 0;
  int    exp_fd     = 0;

  logic               prev_stall    = 1'b0;
  logic               prev_fd       = 1'b0;
  logic               prev_eof_fire = 1'b0;
  logic signed [15:0] prev_data;
  logic               prev_eol;
  logic               prev_eof;

  conv_result_streamer #(
    .SIZE      (5),
    .SIZEKer   (3),
    .WIDTH_BIT (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .convIxKernelOut (mat),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_eol         (out_eol),
    .out_eof         (out_eof),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clock = ~clock;

  assign out_ready = rand_mode ? rnd_ready : ready_level;

  always @(posedge clock) begin
    #2;
    rnd_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: raster walk of the current matrix, optional clamp.
  task automatic push_frame();
    for (int k = 0; k < NB; k++) begin
      beat_t b;
      int    r;
      int    c;
      int    v;
      r = k / OUT;
      c = k % OUT;
      v = mat[r][c];
`ifdef CONV_STREAM_RELU_EN
      if (v < 0) v = 0;
`endif
      b.data = 16'(v);
      b.eol  = (c == OUT - 1);
      b.eof  = (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic fill_formula();
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++)
        mat[r][c] = 16'(r * 3 + c - 4);
  endtask

  task automatic fill_random();
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++)
        mat[r][c] = 16'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, $signed(out_data), 0);
    check({tag, "_eol"}, out_eol, 0);
    check({tag, "_eof"}, out_eof, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Pulse start in IDLE and verify the first beat appears one edge later.
  task automatic start_frame();
    @(posedge clock); #1;
    start = 1'b1;
    push_frame();
    @(posedge clock); #1;
    start = 1'b0;
    check("start_valid", out_valid, 1);
    check("start_busy", busy, 1);
    check("start_first_data", $signed(out_data), exp_q[0].data);
  endtask

  task automatic wait_frame(input string tag);
    exp_fd++;
    for (int i = 0; i < 400 && fd_cnt < exp_fd; i++) begin
      @(posedge clock); #1;
    end
    check({tag, "_frame_done_seen"}, fd_cnt, exp_fd);
    @(posedge clock); #1;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    check({tag, "_one_frame_done"}, fd_cnt, exp_fd);
  endtask

  // Monitor: compare accepted beats, hold stability and frame_done placement.
  always @(negedge clock) begin
    if (!reset) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", $signed(out_data), prev_data);
        check("hold_eol", out_eol, prev_eol);
        check("hold_eof", out_eof, prev_eof);
      end
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", $signed(out_data), b.data);
          check("beat_eol", out_eol, b.eol);
          check("beat_eof", out_eof, b.eof);
          n_accepted++;
        end
      end
      if (frame_done) begin
        check("fd_one_cycle", prev_fd, 0);
        check("fd_follows_eof", prev_eof_fire, 1);
        fd_cnt++;
      end
    end
    prev_fd       = frame_done;
    prev_eof_fire = out_valid && out_ready && out_eof && !reset;
    prev_stall    = out_valid && !out_ready && !reset;
    prev_data     = out_data;
    prev_eol      = out_eol;
    prev_eof      = out_eof;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int k;
    reset = 1'b1;
    start = 1'b0;
    fill_formula();

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // Full-rate frame: 9 back-to-back beats, frame_done right after beat 9.
    start_frame();
    repeat (NB) @(posedge clock);
    #1;
    check("s1_fd_timing", frame_done, 1);
    check("s1_fd_busy", busy, 0);
    exp_fd++;
    @(posedge clock); #1;
    check("s1_fd_drop", frame_done, 0);
    check("s1_count", fd_cnt, exp_fd);
    check("s1_queue", exp_q.size(), 0);

    // Back-pressure on frame cycles 2-4: beat 2 (-3) must be held.
    start_frame();
    @(posedge clock); #1;
    ready_level = 1'b0;
    @(posedge clock); #1;
`ifdef CONV_STREAM_RELU_EN
    check("s2_held_value", $signed(out_data), 0);
`else
    check("s2_held_value", $signed(out_data), -3);
`endif
    repeat (2) @(posedge clock);
    #1;
    ready_level = 1'b1;
    wait_frame("s2");

    // Starts during STREAM and DONE are ignored.
    start_frame();
    repeat (2) @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("s3_busy_mid", busy, 1);
    k = 0;
    while (!frame_done && k < 400) begin
      @(posedge clock); #1;
      k++;
    end
    check("s3_reached_done", frame_done, 1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    exp_fd++;
    check("s3_no_restart_valid", out_valid, 0);
    check("s3_no_restart_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1;
    check("s3_still_idle", out_valid, 0);
    check("s3_one_frame_done", fd_cnt, exp_fd);
    start_frame();
    wait_frame("s3_replay");

    // Reset mid-frame after five accepted beats aborts cleanly.
    start_frame();
    target = n_accepted + 5;
    k = 0;
    while (n_accepted < target && k < 400) begin
      @(posedge clock); #1;
      k++;
    end
    check("s4_reached_beat5", n_accepted >= target, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_quiet("s4_abort");
    exp_q.delete();
    reset = 1'b0;
    @(posedge clock); #1;
    check("s4_stays_idle", out_valid, 0);
    start_frame();
    wait_frame("s4_restart");

    // Random back-pressure over 20 frames with random matrices.
    rand_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      fill_random();
      start_frame();
      wait_frame("s6");
    end
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
